// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RSP_F  = 2'd1,
    RSP_L  = 2'd2,
    RSP_FL = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_LOAD  = 1'b1
  } port_e;

  // RV32I "addi x0, x0, 0", returned as data for rejected accesses.
  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic arb_state_e state_of(input logic f_pend, input logic l_pend);
    case ({f_pend, l_pend})
      2'b10:   return RSP_F;
      2'b01:   return RSP_L;
      2'b11:   return RSP_FL;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/imem_rsp_slot.sv
// One-entry response holding register for a single requester port.
// Read data is forwarded from the memory in the first response cycle, then captured.
module imem_rsp_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        accept,
  input  logic        acc_rd,
  input  logic [31:0] acc_data,
  input  logic        acc_err,
  input  logic [31:0] mem_rdata,
  input  logic        rsp_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        avail
);

  logic        valid_q;
  logic        pass_q;
  logic [31:0] data_q;
  logic        err_q;

  // A new request may land when empty or when the held response leaves this cycle.
  assign avail     = !valid_q || rsp_ready;
  assign rsp_valid = valid_q;
  assign rsp_data  = pass_q ? mem_rdata : data_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pass_q  <= 1'b0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      pass_q  <= acc_rd;
      data_q  <= acc_data;
      err_q   <= acc_err;
    end else if (valid_q && rsp_ready) begin
      valid_q <= 1'b0;
      pass_q  <= 1'b0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else if (pass_q) begin
      // Memory output may change next cycle; freeze it while stalled.
      data_q <= mem_rdata;
      pass_q <= 1'b0;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one single-port instruction memory between core fetch and loader.
// Optional address checking is compiled in with IMEM_ARB_ADDR_CHK_EN.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          boot_hold,
  input  logic          fetch_req_valid,
  output logic          fetch_req_ready,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_rsp_valid,
  input  logic          fetch_rsp_ready,
  output logic [31:0]   fetch_rsp_data,
  output logic          fetch_rsp_err,
  input  logic          load_req_valid,
  output logic          load_req_ready,
  input  logic          load_we,
  input  logic [31:0]   load_addr,
  input  logic [31:0]   load_wdata,
  output logic          load_rsp_valid,
  input  logic          load_rsp_ready,
  output logic [31:0]   load_rsp_data,
  output logic          load_rsp_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output arb_state_e    dbg_state
);

  // Handshake: a request transfers on a rising edge where valid && ready;
  // ready may depend on the other port's valid, never on its own.

  arb_state_e state_q;
  port_e      last_q;
  logic       f_avail, l_avail;
  logic       f_can, l_can, f_want, l_want;
  logic       f_hs, l_hs;
  logic       f_bad, l_bad;

`ifdef IMEM_ARB_ADDR_CHK_EN
  assign f_bad = (fetch_addr[1:0] != 2'b00) || ({2'b00, fetch_addr[31:2]} >= 32'(MEM_WORDS));
  assign l_bad = (load_addr[1:0] != 2'b00)  || ({2'b00, load_addr[31:2]}  >= 32'(MEM_WORDS));
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[31:AW+2], fetch_addr[1:0],
                              load_addr[31:AW+2], load_addr[1:0]};
  assign f_bad = 1'b0;
  assign l_bad = 1'b0;
`endif

  assign f_can  = rst_n && !boot_hold && f_avail;
  assign l_can  = rst_n && l_avail;
  assign f_want = f_can && fetch_req_valid;
  assign l_want = l_can && load_req_valid;

  // On contention the port that lost the previous grant wins.
  assign fetch_req_ready = f_can && (!l_want || (last_q == PORT_LOAD));
  assign load_req_ready  = l_can && (!f_want || (last_q == PORT_FETCH));

  assign f_hs = fetch_req_valid && fetch_req_ready;
  assign l_hs = load_req_valid && load_req_ready;

  assign mem_en    = (f_hs && !f_bad) || (l_hs && !l_bad);
  assign mem_we    = l_hs && !l_bad && load_we;
  assign mem_addr  = l_hs ? load_addr[AW+1:2] : fetch_addr[AW+1:2];
  assign mem_wdata = load_wdata;
  assign dbg_state = state_q;

  imem_rsp_slot u_fetch_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept    (f_hs),
    .acc_rd    (!f_bad),
    .acc_data  (f_bad ? NOP : 32'h0),
    .acc_err   (f_bad),
    .mem_rdata (mem_rdata),
    .rsp_ready (fetch_rsp_ready),
    .rsp_valid (fetch_rsp_valid),
    .rsp_data  (fetch_rsp_data),
    .rsp_err   (fetch_rsp_err),
    .avail     (f_avail)
  );

  imem_rsp_slot u_load_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept    (l_hs),
    .acc_rd    (!l_bad && !load_we),
    .acc_data  (l_bad ? NOP : 32'h0),
    .acc_err   (l_bad),
    .mem_rdata (mem_rdata),
    .rsp_ready (load_rsp_ready),
    .rsp_valid (load_rsp_valid),
    .rsp_data  (load_rsp_data),
    .rsp_err   (load_rsp_err),
    .avail     (l_avail)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= PORT_LOAD;
    end else begin
      case (state_q)
        IDLE:    state_q <= state_of(f_hs, l_hs);
        RSP_F:   state_q <= state_of(f_hs || !fetch_rsp_ready, l_hs);
        RSP_L:   state_q <= state_of(f_hs, l_hs || !load_rsp_ready);
        RSP_FL:  state_q <= state_of(f_hs || !fetch_rsp_ready, l_hs || !load_rsp_ready);
        default: state_q <= IDLE;
      endcase
      if (f_hs)      last_q <= PORT_FETCH;
      else if (l_hs) last_q <= PORT_LOAD;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a behavioural synchronous memory.
module tb_imem_arbiter;
  import imem_pkg::*;

  localparam int MEM_WORDS = 1024;
  localparam int AW        = 10;
  localparam logic [31:0] V0 = 32'h0050_0093;
  localparam logic [31:0] V1 = 32'h00a0_0113;

  logic          clk, rst_n, boot_hold;
  logic          fetch_req_valid, fetch_req_ready;
  logic [31:0]   fetch_addr;
  logic          fetch_rsp_valid, fetch_rsp_ready, fetch_rsp_err;
  logic [31:0]   fetch_rsp_data;
  logic          load_req_valid, load_req_ready, load_we;
  logic [31:0]   load_addr, load_wdata;
  logic          load_rsp_valid, load_rsp_ready, load_rsp_err;
  logic [31:0]   load_rsp_data;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  arb_state_e    dbg_state;

  logic [31:0] mem [MEM_WORDS];
  int total = 0;
  int bad   = 0;

  imem_arbiter #(.MEM_WORDS(MEM_WORDS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .boot_hold(boot_hold),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready), .fetch_addr(fetch_addr),
    .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_ready(fetch_rsp_ready),
    .fetch_rsp_data(fetch_rsp_data), .fetch_rsp_err(fetch_rsp_err),
    .load_req_valid(load_req_valid), .load_req_ready(load_req_ready), .load_we(load_we),
    .load_addr(load_addr), .load_wdata(load_wdata),
    .load_rsp_valid(load_rsp_valid), .load_rsp_ready(load_rsp_ready),
    .load_rsp_data(load_rsp_data), .load_rsp_err(load_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // drivers
  task automatic drop_reqs();
    fetch_req_valid = 1'b0;
    load_req_valid  = 1'b0;
    load_we         = 1'b0;
  endtask

  task automatic do_reset();
    drop_reqs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    fetch_req_valid = 1'b1;
    load_req_valid  = 1'b1;
    #2;
    total++;
    if ({fetch_req_ready, load_req_ready, fetch_rsp_valid, load_rsp_valid, mem_en, mem_we} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {fetch_req_ready, load_req_ready, fetch_rsp_valid, load_rsp_valid, mem_en, mem_we});
    end
    total++;
    if ({fetch_rsp_data, fetch_rsp_err, load_rsp_data, load_rsp_err} !== 66'h0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_data got=%h/%b/%h/%b state=%0d exp=0/0/0/0 state=0",
               fetch_rsp_data, fetch_rsp_err, load_rsp_data, load_rsp_err, dbg_state);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if ({fetch_req_ready, load_req_ready, mem_en, mem_we} !== 4'b1010) begin
      bad++;
      $display("FAIL first_grant got=%b exp=1010", {fetch_req_ready, load_req_ready, mem_en, mem_we});
    end
    @(posedge clk); #1;
    drop_reqs();
    @(negedge clk);
    total++;
    if ({fetch_rsp_valid, load_rsp_valid} !== 2'b10 || fetch_rsp_data !== 32'h0 || dbg_state !== RSP_F) begin
      bad++;
      $display("FAIL first_rsp got=%b/%h state=%0d exp=10/0 state=1",
               {fetch_rsp_valid, load_rsp_valid}, fetch_rsp_data, dbg_state);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    load_req_valid = 1'b1; load_we = 1'b1; load_addr = 32'h0; load_wdata = V0;
    @(negedge clk);
    total++;
    if ({load_req_ready, mem_en, mem_we} !== 3'b111 || mem_addr !== 10'd0 || mem_wdata !== V0) begin
      bad++;
      $display("FAIL wr_issue got=%b addr=%h wdata=%h exp=111 addr=0 wdata=%h",
               {load_req_ready, mem_en, mem_we}, mem_addr, mem_wdata, V0);
    end
    @(posedge clk); #1;
    drop_reqs();
    fetch_req_valid = 1'b1; fetch_addr = 32'h0;
    @(negedge clk);
    total++;
    if ({load_rsp_valid, load_rsp_data, load_rsp_err} !== {1'b1, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL wr_ack got=%b/%h/%b exp=1/0/0", load_rsp_valid, load_rsp_data, load_rsp_err);
    end
    total++;
    if ({fetch_req_ready, mem_en, mem_we} !== 3'b110) begin
      bad++;
      $display("FAIL rd_issue got=%b exp=110", {fetch_req_ready, mem_en, mem_we});
    end
    @(posedge clk); #1;
    drop_reqs();
    @(negedge clk);
    total++;
    if ({fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err, load_rsp_valid} !== {1'b1, V0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rd_data got=%b/%h/%b/%b exp=1/%h/0/0",
               fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err, load_rsp_valid, V0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic exp_f;
    do_reset();
    fetch_req_valid = 1'b1; fetch_addr = 32'h0;
    load_req_valid  = 1'b1; load_we = 1'b0; load_addr = 32'h4;
    for (int i = 0; i < 6; i++) begin
      exp_f = (i % 2 == 0);
      @(negedge clk);
      total++;
      if ({fetch_req_ready, load_req_ready, mem_en} !== {exp_f, !exp_f, 1'b1} ||
          mem_addr !== (exp_f ? 10'd0 : 10'd1)) begin
        bad++;
        $display("FAIL rr_grant[%0d] got=%b addr=%0d exp=%b addr=%0d", i,
                 {fetch_req_ready, load_req_ready, mem_en}, mem_addr, {exp_f, !exp_f, 1'b1}, exp_f ? 0 : 1);
      end
      if (i > 0) begin
        total++;
        if (exp_f ? ({load_rsp_valid, fetch_rsp_valid, load_rsp_data} !== {2'b10, V1})
                  : ({fetch_rsp_valid, load_rsp_valid, fetch_rsp_data} !== {2'b10, V0})) begin
          bad++;
          $display("FAIL rr_rsp[%0d] got=f%b/%h l%b/%h exp=%s", i, fetch_rsp_valid, fetch_rsp_data,
                   load_rsp_valid, load_rsp_data, exp_f ? "load V1" : "fetch V0");
        end
      end
      @(posedge clk); #1;
    end
    drop_reqs();
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    fetch_rsp_ready = 1'b0;
    fetch_req_valid = 1'b1; fetch_addr = 32'h0;
    @(negedge clk);
    total++;
    if (fetch_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_accept got=%b exp=1", fetch_req_ready);
    end
    @(posedge clk); #1;
    fetch_addr = 32'h4;
    load_req_valid = 1'b1; load_we = 1'b0; load_addr = 32'h4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({fetch_req_ready, load_req_ready, mem_en, fetch_rsp_valid} !== 4'b0111 ||
          fetch_rsp_data !== V0 || dbg_state !== ((i == 0) ? RSP_F : RSP_FL)) begin
        bad++;
        $display("FAIL bp_stall[%0d] got=%b data=%h state=%0d exp=0111 data=%h", i,
                 {fetch_req_ready, load_req_ready, mem_en, fetch_rsp_valid}, fetch_rsp_data, dbg_state, V0);
      end
      if (i > 0) begin
        total++;
        if ({load_rsp_valid, load_rsp_data} !== {1'b1, V1}) begin
          bad++;
          $display("FAIL bp_load[%0d] got=%b/%h exp=1/%h", i, load_rsp_valid, load_rsp_data, V1);
        end
      end
      @(posedge clk); #1;
    end
    fetch_rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({fetch_req_ready, load_req_ready} !== 2'b10 || fetch_rsp_data !== V0 || mem_addr !== 10'd1) begin
      bad++;
      $display("FAIL bp_release got=%b data=%h addr=%0d exp=10 data=%h addr=1",
               {fetch_req_ready, load_req_ready}, fetch_rsp_data, mem_addr, V0);
    end
    @(posedge clk); #1;
    drop_reqs();
    @(negedge clk);
    total++;
    if ({fetch_rsp_valid, load_rsp_valid, fetch_rsp_data} !== {2'b10, V1}) begin
      bad++;
      $display("FAIL bp_next got=%b/%h exp=10/%h", {fetch_rsp_valid, load_rsp_valid}, fetch_rsp_data, V1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_boot_hold();
    boot_hold = 1'b1;
    fetch_req_valid = 1'b1; fetch_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({fetch_req_ready, mem_en, fetch_rsp_valid} !== 3'b000) begin
        bad++;
        $display("FAIL hold[%0d] got=%b exp=000", i, {fetch_req_ready, mem_en, fetch_rsp_valid});
      end
      @(posedge clk); #1;
    end
    boot_hold = 1'b0;
    @(negedge clk);
    total++;
    if ({fetch_req_ready, mem_en} !== 2'b11) begin
      bad++;
      $display("FAIL hold_release got=%b exp=11", {fetch_req_ready, mem_en});
    end
    @(posedge clk); #1;
    drop_reqs();
    @(negedge clk);
    total++;
    if ({fetch_rsp_valid, fetch_rsp_data} !== {1'b1, V0}) begin
      bad++;
      $display("FAIL hold_rsp got=%b/%h exp=1/%h", fetch_rsp_valid, fetch_rsp_data, V0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_addr_bits();
    logic [31:0] a_tab [2];
    logic [32:0] r_tab [2];
    logic [1:0]  e_tab [2];
    a_tab[0] = 32'h0000_0002;
    a_tab[1] = 32'h0000_1000;
`ifdef IMEM_ARB_ADDR_CHK_EN
    r_tab[0] = {NOP, 1'b1};
    r_tab[1] = {NOP, 1'b1};
    e_tab[0] = 2'b10;
    e_tab[1] = 2'b10;
`else
    a_tab[1] = 32'h0000_1004;
    r_tab[0] = {V0, 1'b0};
    r_tab[1] = {V1, 1'b0};
    e_tab[0] = 2'b11;
    e_tab[1] = 2'b11;
`endif
    for (int i = 0; i < 2; i++) begin
      fetch_req_valid = 1'b1; fetch_addr = a_tab[i];
      @(negedge clk);
      total++;
      if ({fetch_req_ready, mem_en} !== e_tab[i]) begin
        bad++;
        $display("FAIL addr_issue[%0d] got=%b exp=%b", i, {fetch_req_ready, mem_en}, e_tab[i]);
      end
      @(posedge clk); #1;
      drop_reqs();
      @(negedge clk);
      total++;
      if ({fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err} !== {1'b1, r_tab[i]}) begin
        bad++;
        $display("FAIL addr_rsp[%0d] got=%b/%h/%b exp=1/%h/%b", i, fetch_rsp_valid, fetch_rsp_data,
                 fetch_rsp_err, r_tab[i][32:1], r_tab[i][0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_inflight();
    fetch_req_valid = 1'b1; fetch_addr = 32'h4;
    @(negedge clk);
    total++;
    if (fetch_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL inflight_accept got=%b exp=1", fetch_req_ready);
    end
    @(posedge clk); #1;
    drop_reqs();
    rst_n = 1'b0;
    #1;
    total++;
    if ({fetch_rsp_valid, load_rsp_valid, fetch_req_ready, load_req_ready, mem_en, mem_we} !== 6'b0 ||
        {fetch_rsp_data, fetch_rsp_err, load_rsp_data, load_rsp_err} !== 66'h0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL inflight_reset got=%b data=%h/%h state=%0d exp=000000 data=0/0 state=0",
               {fetch_rsp_valid, load_rsp_valid, fetch_req_ready, load_req_ready, mem_en, mem_we},
               fetch_rsp_data, load_rsp_data, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({fetch_rsp_valid, mem_en, dbg_state} !== {2'b00, IDLE}) begin
        bad++;
        $display("FAIL inflight_after[%0d] got=%b/%b state=%0d exp=0/0 state=0", i,
                 fetch_rsp_valid, mem_en, dbg_state);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
    mem[1] = V1;
    mem_rdata = 32'h0;
    rst_n = 1'b0;
    boot_hold = 1'b0;
    fetch_req_valid = 1'b0; fetch_addr = 32'h0; fetch_rsp_ready = 1'b1;
    load_req_valid = 1'b0; load_we = 1'b0; load_addr = 32'h0; load_wdata = 32'h0;
    load_rsp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_round_robin();
    test_backpressure();
    test_boot_hold();
    test_addr_bits();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached without completion");
    $fatal(1);
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter AW, default $clog2(MEM_WORDS), meaning word-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port boot_hold  input  1  when 1, fetch port is not granted.
REQ-006 SHALL have ports fetch_req_valid in 1, fetch_req_ready out 1, fetch_addr in 32  core fetch request (byte address).
REQ-007 SHALL have ports fetch_rsp_valid out 1, fetch_rsp_ready in 1, fetch_rsp_data out 32, fetch_rsp_err out 1  fetch response.
REQ-008 SHALL have ports load_req_valid in 1, load_req_ready out 1, load_we in 1, load_addr in 32, load_wdata in 32  loader request (read or write).
REQ-009 SHALL have ports load_rsp_valid out 1, load_rsp_ready in 1, load_rsp_data out 32, load_rsp_err out 1  loader response.
REQ-010 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out AW, mem_wdata out 32, mem_rdata in 32  single-port synchronous memory, read data one cycle after mem_en.

Function
REQ-011 SHALL perform at most one memory access per cycle, issued combinationally in the cycle a request handshake (valid && ready) occurs; mem_addr = req_addr[AW+1:2].
REQ-012 SHALL assert a port's response valid exactly one cycle after its accepted request, and hold response valid/data/err stable until rsp_ready.
REQ-013 SHALL return mem_rdata for reads and 32'h0 for writes (write acknowledge), err = 0 unless REQ-024 applies.
REQ-014 SHALL deassert a port's req_ready while that port's response register is full and not being drained this cycle; full-and-draining allows back-to-back acceptance.
REQ-015 SHALL arbitrate round-robin when both ports are eligible: grant the port not granted most recently; a lone eligible port is granted every cycle.
REQ-016 SHALL keep FSM states IDLE (no response pending), RSP_F (fetch response pending), RSP_L (loader response pending), RSP_FL (both pending); transitions follow accept and drain events in the same cycle.
REQ-017 SHALL treat fetch as ineligible while boot_hold = 1; a fetch response already pending still completes normally.
REQ-018 SHALL never assert mem_we for the fetch port; mem_we = load_we only on loader grant.
REQ-019 SHALL hold mem_en, mem_we = 0 in any cycle with no handshake; mem_addr/mem_wdata are don't-care then.

Reset
REQ-020 SHALL on rst_n = 0 immediately force: FSM IDLE, all rsp_valid = 0, rsp_data = 0, rsp_err = 0, mem_en = 0, mem_we = 0, req_ready = 0, round-robin pointer = loader-last (fetch wins first tie).
REQ-021 SHALL discard any in-flight access on reset; no response is produced for it after reset release.
REQ-022 SHALL first accept a request in the first rising edge after rst_n deasserts.

Configuration
REQ-023 SHALL compile the address-check feature only when macro IMEM_ARB_ADDR_CHK_EN is defined.
REQ-024 SHALL with IMEM_ARB_ADDR_CHK_EN: accept a request with addr[1:0] != 0 or addr[31:2] >= MEM_WORDS without memory access (mem_en = 0), respond next cycle with err = 1, data = 32'h00000013.
REQ-025 SHALL without IMEM_ARB_ADDR_CHK_EN: ignore addr[1:0] and upper bits, tie rsp_err outputs to 0.

Structure
REQ-026 SHALL place the FSM state enum, the NOP constant 32'h00000013 and the port-id enum (PORT_FETCH, PORT_LOAD) in shared package imem_pkg.
REQ-027 SHALL implement the per-port response holding register as one sub-module, imem_rsp_slot, instantiated twice.

Verification
REQ-028 SHALL cover: loader writes 32'h00500093 to addr 0x0, then fetch addr 0x0 -> fetch_rsp_data = 32'h00500093 one cycle after accept, err = 0.
REQ-029 SHALL cover: both ports valid every cycle, both rsp_ready = 1 -> grants alternate F,L,F,L from reset, one mem_en per cycle.
REQ-030 SHALL cover: fetch_rsp_ready = 0 for 3 cycles -> fetch_req_ready = 0, fetch_rsp_data stable, loader still served.
REQ-031 SHALL cover: boot_hold = 1 with fetch_req_valid = 1 for 5 cycles -> no fetch grant; release -> fetch granted next cycle.
REQ-032 SHALL cover: with IMEM_ARB_ADDR_CHK_EN, fetch addr 0x2 and addr 0x1000 -> mem_en = 0, rsp err = 1, data 32'h00000013.
REQ-033 SHALL cover: rst_n asserted in the cycle after a fetch accept -> no fetch_rsp_valid after release, all outputs at reset values.
